// File: rtl/alarm_clock_ctrl_pkg.sv
// Shared definitions for the alarm-clock sequencer: state encoding,
// the idle key code, the output strobe bundle and small decode helpers.
package alarm_clock_ctrl_pkg;

  // Keypad code reported when no key is pressed (11..15 behave the same)
  localparam logic [3:0] NOKEY = 4'd10;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  typedef struct packed {
    logic load_new_a;
    logic load_new_c;
    logic show_a;
    logic show_new_time;
    logic shift;
    logic reset_count;
  } ctrl_outs_t;

  // True for keypad codes 0..9; everything else counts as "no key"
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  // Moore output decode: strobes depend on the state alone
  function automatic ctrl_outs_t decode_outputs(input state_t s);
    ctrl_outs_t o;
    o = '{default: 1'b0};
    case (s)
      SHOW_TIME: begin
        o = '{default: 1'b0};
      end
      KEY_STORED: begin
        o.shift         = 1'b1;
        o.show_new_time = 1'b1;
      end
      KEY_WAITED: begin
        o.show_new_time = 1'b1;
      end
      KEY_ENTRY: begin
        o.show_new_time = 1'b1;
      end
      SHOW_ALARM: begin
        o.show_a = 1'b1;
      end
      SET_ALARM_TIME: begin
        o.load_new_a = 1'b1;
      end
      SET_CURRENT_TIME: begin
        o.load_new_c  = 1'b1;
        o.reset_count = 1'b1;
      end
      default: begin
        o = '{default: 1'b0};
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alarm_clock_ctrl_entry_timeout.sv
// Saturating seconds counter that abandons a stalled key entry.
// Counts one_second pulses while enabled, clears on request and flags
// the pulse that completes TIMEOUT_SECS seconds without progress.
// Only instantiated when ALARM_CLOCK_CTRL_TIMEOUT_EN is defined.
module alarm_clock_ctrl_entry_timeout #(
  parameter int TIMEOUT_SECS = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic one_second,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_SECS + 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_SECS - 1);

  logic [CW-1:0] count_r;

  // Seconds elapsed since the last key progress; sticks at all-ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && one_second && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // The pulse that would make the count reach TIMEOUT_SECS is the timeout
  assign timeout = one_second && (count_r == CNT_LAST);

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Moore sequencer for the alarm-clock datapath. Turns keypad digits and
// the ALARM/TIME buttons into shift, load, display-select and
// reset_count strobes. All strobes are registered copies of the decode of
// the next state, so there is no combinational input-to-output path.
// Optional key-entry timeout: define ALARM_CLOCK_CTRL_TIMEOUT_EN.
import alarm_clock_ctrl_pkg::*;

module alarm_clock_ctrl #(
  parameter int TIMEOUT_SECS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_a,
  output logic       show_new_time,
  output logic       shift,
  output logic       reset_count
);

  state_t     state_r;
  state_t     next_s;
  ctrl_outs_t outs_r;
  logic       digit_s;
  logic       timeout_s;

  assign digit_s = is_digit(key);

`ifdef ALARM_CLOCK_CTRL_TIMEOUT_EN
  logic waiting_s;

  // The counter only runs while the sequencer is waiting for key progress
  assign waiting_s = (state_r == KEY_WAITED) || (state_r == KEY_ENTRY);

  alarm_clock_ctrl_entry_timeout #(
    .TIMEOUT_SECS (TIMEOUT_SECS)
  ) u_entry_timeout (
    .clock      (clock),
    .reset      (reset),
    .clear      (!waiting_s),
    .enable     (waiting_s),
    .one_second (one_second),
    .timeout    (timeout_s)
  );
`else
  localparam int unused_timeout_secs_p = TIMEOUT_SECS;
  logic unused_one_second_s;

  assign unused_one_second_s = one_second;
  assign timeout_s           = 1'b0;
`endif

  // Next-state rules; button priority in KEY_ENTRY is alarm, time, digit, timeout
  always_comb begin
    next_s = state_r;
    case (state_r)
      SHOW_TIME: begin
        if (alarm_button) begin
          next_s = SHOW_ALARM;
        end else if (digit_s) begin
          next_s = KEY_STORED;
        end else begin
          next_s = SHOW_TIME;
        end
      end
      KEY_STORED: begin
        next_s = KEY_WAITED;
      end
      KEY_WAITED: begin
        if (!digit_s) begin
          next_s = KEY_ENTRY;
        end else if (timeout_s) begin
          next_s = SHOW_TIME;
        end else begin
          next_s = KEY_WAITED;
        end
      end
      KEY_ENTRY: begin
        if (alarm_button) begin
          next_s = SET_ALARM_TIME;
        end else if (time_button) begin
          next_s = SET_CURRENT_TIME;
        end else if (digit_s) begin
          next_s = KEY_STORED;
        end else if (timeout_s) begin
          next_s = SHOW_TIME;
        end else begin
          next_s = KEY_ENTRY;
        end
      end
      SHOW_ALARM, SET_ALARM_TIME: begin
        if (!alarm_button) begin
          next_s = SHOW_TIME;
        end else begin
          next_s = state_r;
        end
      end
      SET_CURRENT_TIME: begin
        if (!time_button) begin
          next_s = SHOW_TIME;
        end else begin
          next_s = SET_CURRENT_TIME;
        end
      end
      default: begin
        next_s = SHOW_TIME;
      end
    endcase
  end

  // State register with strobes registered from the decode of the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= SHOW_TIME;
      outs_r  <= '{default: 1'b0};
    end else begin
      state_r <= next_s;
      outs_r  <= decode_outputs(next_s);
    end
  end

  assign load_new_a    = outs_r.load_new_a;
  assign load_new_c    = outs_r.load_new_c;
  assign show_a        = outs_r.show_a;
  assign show_new_time = outs_r.show_new_time;
  assign shift         = outs_r.shift;
  assign reset_count   = outs_r.reset_count;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Self-checking bench for alarm_clock_ctrl: directed scenarios with
// literal expectations plus a randomized run compared every cycle against
// a mode-based behavioural model of the sequencer.
module tb_alarm_clock_ctrl;

  localparam int         TOUT = 10;
  localparam logic [3:0] NK   = 4'd10;
`ifdef ALARM_CLOCK_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int SECS_MAX = (1 << $clog2(TOUT + 1)) - 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       load_new_a, load_new_c, show_a, show_new_time, shift, reset_count;
  logic [5:0] dut_v;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: mode 0 clock display, 1 alarm display, 2 loading alarm,
  // 3 loading time, 4 key entry. In entry, 'fresh' marks the cycle a new
  // digit is taken and 'held' marks waiting for that key to be released.
  int mode  = 0;
  bit fresh = 1'b0;
  bit held  = 1'b0;
  int secs  = 0;

  alarm_clock_ctrl #(.TIMEOUT_SECS(TOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .one_second    (one_second),
    .key           (key),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .show_a        (show_a),
    .show_new_time (show_new_time),
    .shift         (shift),
    .reset_count   (reset_count)
  );

  assign dut_v = {load_new_a, load_new_c, show_a, show_new_time, shift, reset_count};

  always #5 clock = ~clock;

  function automatic logic [5:0] exp_vec();
    logic [5:0] v;
    v[5] = (mode == 2);
    v[4] = (mode == 3);
    v[3] = (mode == 1);
    v[2] = (mode == 4);
    v[1] = (mode == 4) && fresh;
    v[0] = (mode == 3);
    return v;
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic a, input logic t, input logic [3:0] k, input logic os);
    bit dig;
    bit waiting;
    bit to_hit;
    int nsecs;
    dig     = (k <= 4'd9);
    waiting = (mode == 4) && !fresh;
    to_hit  = TO_EN && os && (secs == TOUT - 1);
    nsecs   = waiting ? ((os && secs < SECS_MAX) ? secs + 1 : secs) : 0;
    if (reset) begin
      mode = 0; fresh = 1'b0; held = 1'b0; secs = 0;
    end else begin
      case (mode)
        0: begin
          if (a) mode = 1;
          else if (dig) begin mode = 4; fresh = 1'b1; held = 1'b0; end
        end
        1, 2: if (!a) mode = 0;
        3:    if (!t) mode = 0;
        4: begin
          if (fresh) begin
            fresh = 1'b0; held = 1'b1;
          end else if (held) begin
            if (!dig) held = 1'b0;
            else if (to_hit) mode = 0;
          end else begin
            if (a) mode = 2;
            else if (t) mode = 3;
            else if (dig) begin fresh = 1'b1; held = 1'b0; end
            else if (to_hit) mode = 0;
          end
        end
        default: mode = 0;
      endcase
      secs = nsecs;
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, return at the falling edge
  task automatic cyc(input logic a, input logic t, input logic [3:0] k, input logic os);
    alarm_button = a;
    time_button  = t;
    key          = k;
    one_second   = os;
    @(posedge clock);
    model_step(a, t, k, os);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, NK, 1'b0);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (cmp_en) chk("model", dut_v, exp_vec());
  end

  initial begin
    int cnt;
    int cnt2;
    reset = 1'b1; alarm_button = 1'b0; time_button = 1'b0; key = NK; one_second = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_state", dut_v, 6'b000000);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Key 5 held 20 cycles: one shift, entry display persists after release
    cyc(1'b0, 1'b0, 4'd5, 1'b0);
    chk("key5_first", dut_v, 6'b000110);
    cnt = shift;
    repeat (19) begin cyc(1'b0, 1'b0, 4'd5, 1'b0); cnt += shift; end
    chk_int("key5_shift_pulses", cnt, 1);
    idle(3);
    chk("key5_released", dut_v, 6'b000100);
    cyc(1'b1, 1'b0, NK, 1'b0);
    chk("key5_set_alarm", dut_v, 6'b100000);
    idle(1);
    chk("key5_back_idle", dut_v, 6'b000000);

    // Digits 1..4 then TIME held 3 cycles
    cnt = 0;
    for (int d = 1; d <= 4; d++) begin
      cyc(1'b0, 1'b0, 4'(d), 1'b0); cnt += shift;
      cyc(1'b0, 1'b0, NK, 1'b0);    cnt += shift;
      cyc(1'b0, 1'b0, NK, 1'b0);    cnt += shift;
    end
    chk_int("digits_shift_pulses", cnt, 4);
    cnt = 0;
    repeat (3) begin cyc(1'b0, 1'b1, NK, 1'b0); cnt += (load_new_c && reset_count) ? 1 : 0; end
    chk_int("time_load_cycles", cnt, 3);
    idle(1);
    chk("time_released", dut_v, 6'b000000);

    // Digit 7 then ALARM and TIME together: alarm wins
    cyc(1'b0, 1'b0, 4'd7, 1'b0);
    idle(2);
    cyc(1'b1, 1'b1, NK, 1'b0);
    chk("both_buttons", dut_v, 6'b100000);
    cnt = load_new_c;
    repeat (2) begin cyc(1'b1, 1'b1, NK, 1'b0); cnt += load_new_c; end
    chk_int("both_no_load_c", cnt, 0);
    cyc(1'b0, 1'b1, NK, 1'b0);
    cyc(1'b0, 1'b1, NK, 1'b0);
    chk("time_ignored_idle", dut_v, 6'b000000);
    idle(1);

    // ALARM from clock display held 4 cycles
    cnt = 0;
    repeat (4) begin cyc(1'b1, 1'b0, NK, 1'b0); cnt += show_a; end
    chk_int("show_a_cycles", cnt, 4);
    idle(1);
    chk("show_a_release", dut_v, 6'b000000);

`ifdef ALARM_CLOCK_CTRL_TIMEOUT_EN
    // Timeout after ten idle seconds
    cyc(1'b0, 1'b0, 4'd3, 1'b0);
    idle(2);
    for (int p = 1; p <= 10; p++) begin
      idle(2);
      cyc(1'b0, 1'b0, NK, 1'b1);
      if (p == 9) chk("timeout_p9", dut_v, 6'b000100);
    end
    chk("timeout_p10", dut_v, 6'b000000);
    // A digit on the 9th pulse restarts the count
    cyc(1'b0, 1'b0, 4'd3, 1'b0);
    idle(2);
    for (int p = 1; p <= 8; p++) begin idle(2); cyc(1'b0, 1'b0, NK, 1'b1); end
    cyc(1'b0, 1'b0, 4'd3, 1'b1);
    chk("restart_shift", dut_v, 6'b000110);
    idle(2);
    cnt2 = 0;
    for (int p = 1; p <= 10; p++) begin
      idle(2);
      cyc(1'b0, 1'b0, NK, 1'b1);
      if (p == 9) chk("restart_p9", dut_v, 6'b000100);
    end
    chk("restart_p10", dut_v, 6'b000000);
`endif

    // Reset in the middle of an entry clears everything at once
    cyc(1'b0, 1'b0, 4'd8, 1'b0);
    idle(2);
    chk("pre_reset_entry", dut_v, 6'b000100);
    #2 reset = 1'b1;
    #1 chk("async_reset", dut_v, 6'b000000);
    mode = 0; fresh = 1'b0; held = 1'b0; secs = 0;
    cyc(1'b0, 1'b1, NK, 1'b0);
    reset = 1'b0;
    idle(1);
    chk("after_reset", dut_v, 6'b000000);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic a, t, os;
      logic [3:0] k;
      a  = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 7) == 0);
      os = ($urandom_range(0, 3) == 0);
      k  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : NK;
      cyc(a, t, k, os);
    end
    idle(3);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_clock_ctrl.md
# alarm_clock_ctrl

Moore sequencer for the alarm-clock datapath: decodes keypad digits and the ALARM/TIME buttons into load, shift, display-select and `reset_count` strobes. Drives the key shift register, alarm register, current-time counter, LCD mux and time generator (`reset_count`). Provides a seconds-based key-entry timeout clocked by the time generator's `one_second` pulse.

## Interface
- `TIMEOUT_SECS`, 10, number of `one_second` pulses without progress before key entry is abandoned (range 2..15).
- `NOKEY`, 4'd10, key code meaning "no key pressed".
- `clock`  in  1  system clock (256 Hz domain).
- `reset`  in  1  asynchronous, active-high.
- `one_second`  in  1  one-cycle pulse from time generator.
- `key`  in  4  keypad code; 0..9 digit, `NOKEY` idle; values 11..15 treated as `NOKEY`.
- `alarm_button`  in  1  level, synchronous to `clock`.
- `time_button`  in  1  level, synchronous to `clock`.
- `load_new_a`  out  1  load key buffer into alarm register.
- `load_new_c`  out  1  load key buffer into current-time counter.
- `show_a`  out  1  LCD shows alarm time.
- `show_new_time`  out  1  LCD shows key buffer.
- `shift`  out  1  shift current digit into key buffer.
- `reset_count`  out  1  clears time generator prescaler.

## Operation
- States: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME. "Digit" = `key` in 0..9.
- SHOW_TIME: `alarm_button` -> SHOW_ALARM; else digit -> KEY_STORED; else stay.
- KEY_STORED: unconditional -> KEY_WAITED (exactly one cycle).
- KEY_WAITED: not digit -> KEY_ENTRY; else timeout -> SHOW_TIME; else stay (key held).
- KEY_ENTRY, priority highest first: `alarm_button` -> SET_ALARM_TIME; `time_button` -> SET_CURRENT_TIME; digit -> KEY_STORED; timeout -> SHOW_TIME; else stay.
- SHOW_ALARM: `alarm_button`=0 -> SHOW_TIME.
- SET_ALARM_TIME: `alarm_button`=0 -> SHOW_TIME.
- SET_CURRENT_TIME: `time_button`=0 -> SHOW_TIME.
- Outputs (Moore, decoded from state only): `shift`=1 in KEY_STORED; `show_new_time`=1 in KEY_STORED, KEY_WAITED, KEY_ENTRY; `show_a`=1 in SHOW_ALARM; `load_new_a`=1 in SET_ALARM_TIME; `load_new_c`=1 and `reset_count`=1 in SET_CURRENT_TIME; all else 0.
- Timeout counter: width ceil(log2(TIMEOUT_SECS+1)); cleared in any state other than KEY_WAITED/KEY_ENTRY and in KEY_STORED; increments on `one_second` while in KEY_WAITED or KEY_ENTRY; saturates, never wraps. Timeout = `one_second` && count == TIMEOUT_SECS-1.
- Button held through return to SHOW_TIME: `alarm_button` still high in SHOW_TIME re-enters SHOW_ALARM (intended); `time_button` ignored in SHOW_TIME.

## Timing
- Reset: state SHOW_TIME, timeout count 0, all outputs 0, asynchronously.
- Input sampled at edge N -> state change at edge N -> outputs valid after edge N (one-cycle latency, no combinational input-to-output path).
- `shift` is exactly one cycle per distinct key press regardless of hold length.
- `load_new_a`/`load_new_c`/`reset_count` stay high every cycle the button is held; downstream loads are idempotent.
- Reset asserted mid-entry abandons the entry; no load strobe issued.

## Configuration
- `ALARM_CLOCK_CTRL_TIMEOUT_EN`: defined -> timeout counter and timeout transitions present as above. Undefined -> no counter, timeout term constant 0; KEY_WAITED/KEY_ENTRY wait indefinitely; `one_second` unused.

## Structure
- Shared package: state encoding (3-bit enum/localparams), `NOKEY` constant, digit-check helper.
- One sub-module natural: `entry_timeout` (saturating `one_second` counter with clear/enable, timeout flag); omitted when macro undefined.

## Test plan
- Reset mid-KEY_ENTRY -> state SHOW_TIME, all six outputs 0 immediately.
- `key`=5 held 20 cycles from SHOW_TIME -> `shift` high exactly 1 cycle, `show_new_time` high from cycle 1 until key released and beyond.
- Digits 1,2,3,4 then `time_button` held 3 cycles -> 4 `shift` pulses, `load_new_c`=`reset_count`=1 for 3 cycles, then SHOW_TIME.
- Digit 7 then `alarm_button` and `time_button` asserted same cycle -> SET_ALARM_TIME, `load_new_a`=1, `load_new_c` never 1.
- Macro on, digit then 10 `one_second` pulses with no input -> SHOW_TIME after 10th pulse, `show_new_time` falls; digit at 9th pulse restarts count.
- `alarm_button` from SHOW_TIME held 4 cycles -> `show_a`=1 for 4 cycles, 0 one cycle after release.
